config_frame_loader: RTL and testbench

- Configuration front end that converts a 32-bit bitstream word stream into frame writes for the tile configuration latches.
- Hunts for a sync word, then decodes header/data word pairs.
- Drives the shared FrameData bus and a per-column, per-frame FrameStrobe pulse of programmable width.
- Sits between the bitstream source (UART/SPI/host loader) and the column FrameData/FrameStrobe distribution into the tiles' config memories.

---
 rtl/config_frame_loader_if.sv | 28 ++
 rtl/config_frame_loader.sv | 153 +++++++++++++++
 tb/tb_config_frame_loader.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_frame_loader_if.sv
// Bitstream-in / frame-write-out signal bundle for the configuration frame loader.
// The loader takes the slave view; the word source and the column fabric take the master view.
interface config_frame_loader_if #(
    parameter int unsigned NumColumns      = 8,
    parameter int unsigned MaxFramesPerCol = 32
);
    localparam int unsigned FrameBitsPerRow = 32;
    localparam int unsigned StrobeW         = NumColumns * MaxFramesPerCol;

    logic [31:0]                WriteData;
    logic                       WriteStrobe;
    logic                       Ready;
    logic [FrameBitsPerRow-1:0] FrameData;
    logic [StrobeW-1:0]         FrameStrobe;
    logic                       Active;
    logic                       Error;
    logic [15:0]                FramesWritten;

    modport master (
        output WriteData, WriteStrobe,
        input  Ready, FrameData, FrameStrobe, Active, Error, FramesWritten
    );

    modport slave (
        input  WriteData, WriteStrobe,
        output Ready, FrameData, FrameStrobe, Active, Error, FramesWritten
    );
endinterface

// File: rtl/config_frame_loader.sv
// Bitstream word parser: hunts for the sync word, decodes header/data pairs and
// emits one registered FrameData write with a single-bit FrameStrobe pulse per frame.
module config_frame_loader #(
    parameter int unsigned MaxFramesPerCol = 32,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned NumColumns      = 8,
    parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1,
    parameter int unsigned StrobeCycles    = 2
) (
    input  logic                 CLK,
    input  logic                 resetn,
    config_frame_loader_if.slave bus
);

    localparam int unsigned StrobeW   = NumColumns * MaxFramesPerCol;
    localparam int unsigned IdxW      = (StrobeW > 1) ? $clog2(StrobeW) : 1;
    localparam int unsigned CntW      = 4;
    localparam logic [7:0]  OpWrite   = 8'h01;
    localparam logic [7:0]  OpDesync  = 8'h0F;

    typedef enum logic [1:0] {
        S_HUNT,
        S_HEADER,
        S_DATA,
        S_STROBE
    } state_e;

    state_e                     state_q, state_d;
    logic [7:0]                 col_q, col_d;
    logic [4:0]                 frame_q, frame_d;
    logic [FrameBitsPerRow-1:0] data_q, data_d;
    logic [StrobeW-1:0]         strobe_q, strobe_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic                       error_q, error_d;
    logic [15:0]                frames_q, frames_d;
    logic                       ready_q, ready_d;
    logic                       active_q, active_d;

    logic                       accept_c;
    logic [7:0]                 hdr_op_c;
    logic [7:0]                 hdr_col_c;
    logic [4:0]                 hdr_frame_c;
    logic                       hdr_in_range_c;
    logic [IdxW-1:0]            strobe_idx_c;

    // Header fields and the flat strobe index of the latched column/frame.
    assign accept_c       = bus.WriteStrobe && ready_q;
    assign hdr_op_c       = bus.WriteData[31:24];
    assign hdr_col_c      = bus.WriteData[15:8];
    assign hdr_frame_c    = bus.WriteData[4:0];
    assign hdr_in_range_c = (32'(hdr_col_c) < NumColumns) &&
                            (32'(hdr_frame_c) < MaxFramesPerCol);
    assign strobe_idx_c   = IdxW'(col_q) * IdxW'(MaxFramesPerCol) + IdxW'(frame_q);

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        frame_d  = frame_q;
        data_d   = data_q;
        strobe_d = strobe_q;
        cnt_d    = cnt_q;
        error_d  = error_q;
        frames_d = frames_q;

        unique case (state_q)
            S_HUNT: begin
                if (accept_c && (bus.WriteData == SyncWord)) begin
                    state_d = S_HEADER;
                end
            end

            S_HEADER: begin
                if (accept_c && (bus.WriteData != SyncWord)) begin
                    if ((hdr_op_c == OpWrite) && hdr_in_range_c) begin
                        col_d   = hdr_col_c;
                        frame_d = hdr_frame_c;
                        state_d = S_DATA;
                    end else if (hdr_op_c == OpDesync) begin
                        state_d = S_HUNT;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_HUNT;
                    end
                end
            end

            S_DATA: begin
                if (accept_c) begin
                    data_d   = FrameBitsPerRow'(bus.WriteData);
                    strobe_d = StrobeW'(1) << strobe_idx_c;
                    cnt_d    = CntW'(StrobeCycles - 1);
                    state_d  = S_STROBE;
                end
            end

            S_STROBE: begin
                // Pulse already high since the data edge; cnt_q counts remaining edges.
                if (cnt_q == '0) begin
                    strobe_d = '0;
                    state_d  = S_HEADER;
                    if (frames_q != 16'hFFFF) begin
                        frames_d = frames_q + 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end

            default: begin
                state_d  = S_HUNT;
                strobe_d = '0;
            end
        endcase

        ready_d  = (state_d != S_STROBE);
        active_d = (state_d != S_HUNT);
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_HUNT;
            col_q    <= '0;
            frame_q  <= '0;
            data_q   <= '0;
            strobe_q <= '0;
            cnt_q    <= '0;
            error_q  <= 1'b0;
            frames_q <= '0;
            ready_q  <= 1'b1;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            frame_q  <= frame_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
            error_q  <= error_d;
            frames_q <= frames_d;
            ready_q  <= ready_d;
            active_q <= active_d;
        end
    end

    assign bus.Ready         = ready_q;
    assign bus.FrameData     = data_q;
    assign bus.FrameStrobe   = strobe_q;
    assign bus.Active        = active_q;
    assign bus.Error         = error_q;
    assign bus.FramesWritten = frames_q;

endmodule

// File: tb/tb_config_frame_loader.sv
// Bench for config_frame_loader: directed scenarios plus random word streams checked
// against a word-level protocol model and an expected-frame-write queue.
module tb_config_frame_loader;

    localparam int unsigned NC   = 8;
    localparam int unsigned MF   = 32;
    localparam int unsigned SW   = NC * MF;
    localparam int unsigned SC   = 2;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic CLK    = 1'b0;
    logic resetn = 1'b0;

    always #5 CLK = ~CLK;

    config_frame_loader_if #(.NumColumns(NC), .MaxFramesPerCol(MF)) bus ();
    config_frame_loader_if #(.NumColumns(NC), .MaxFramesPerCol(MF)) busb ();

    config_frame_loader #(
        .MaxFramesPerCol(MF), .FrameBitsPerRow(32), .NumColumns(NC),
        .SyncWord(SYNC), .StrobeCycles(SC)
    ) dut (
        .CLK(CLK), .resetn(resetn), .bus(bus)
    );

    config_frame_loader #(
        .MaxFramesPerCol(MF), .FrameBitsPerRow(32), .NumColumns(NC),
        .SyncWord(SYNC), .StrobeCycles(1)
    ) dut_sc1 (
        .CLK(CLK), .resetn(resetn), .bus(busb)
    );

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // 999 = no bit set, 1000+n = n bits set, otherwise the index of the single set bit.
    function automatic int strobe_code(input logic [SW-1:0] v);
        int n;
        n = $countones(v);
        if (n == 0) return 999;
        if (n > 1) return 1000 + n;
        for (int i = 0; i < int'(SW); i++) if (v[i]) return i;
        return 2000;
    endfunction

    // ---------------- word-level reference model ----------------
    typedef struct {
        int          idx;
        logic [31:0] data;
        longint      acc_cyc;
    } wr_t;

    wr_t         exp_q[$];
    bit          m_synced, m_expect_data, m_error;
    int          m_count;
    int          m_col, m_frame;
    logic [31:0] last_data;
    longint      cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void model_reset();
        m_synced      = 1'b0;
        m_expect_data = 1'b0;
        m_error       = 1'b0;
        m_count       = 0;
        exp_q.delete();
        last_data     = '0;
    endfunction

    // Called at the falling edge before the rising edge that consumes w.
    function automatic void model_accept(input logic [31:0] w);
        wr_t e;
        if (!m_synced) begin
            if (w == SYNC) m_synced = 1'b1;
        end else if (m_expect_data) begin
            e.idx     = m_col * int'(MF) + m_frame;
            e.data    = w;
            e.acc_cyc = cyc + 1;
            exp_q.push_back(e);
            m_expect_data = 1'b0;
            if (m_count < 65535) m_count++;
        end else if (w == SYNC) begin
            // no-op while synced
        end else if (w[31:24] == 8'h01 && int'(w[15:8]) < int'(NC) && int'(w[4:0]) < int'(MF)) begin
            m_col         = int'(w[15:8]);
            m_frame       = int'(w[4:0]);
            m_expect_data = 1'b1;
        end else if (w[31:24] == 8'h0F) begin
            m_synced = 1'b0;
        end else begin
            m_error  = 1'b1;
            m_synced = 1'b0;
        end
    endfunction

    // Every cycle: strobe, Ready and FrameData against the expected write queue.
    always @(negedge CLK) begin : mon
        int          exp_idx;
        logic [31:0] exp_fd;
        bit          in_win;
        if (resetn) begin
            exp_idx = 999;
            exp_fd  = last_data;
            in_win  = 1'b0;
            if (exp_q.size() > 0 && cyc >= exp_q[0].acc_cyc) begin
                exp_fd = exp_q[0].data;
                if (cyc <= exp_q[0].acc_cyc + SC - 1) begin
                    exp_idx = exp_q[0].idx;
                    in_win  = 1'b1;
                end
            end
            check_eq("strobe", 64'(strobe_code(bus.FrameStrobe)), 64'(exp_idx));
            check_eq("ready", 64'(bus.Ready), 64'(!in_win));
            check_eq("framedata", 64'(bus.FrameData), 64'(exp_fd));
            if (in_win && cyc == exp_q[0].acc_cyc + SC - 1) begin
                last_data = exp_q[0].data;
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_word(input logic [31:0] w);
        bit acc;
        acc = 1'b0;
        bus.WriteData   = w;
        bus.WriteStrobe = 1'b1;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge CLK);
            if (bus.Ready === 1'b1) begin
                model_accept(w);
                acc = 1'b1;
            end
            @(posedge CLK);
            #1;
        end
        bus.WriteStrobe = 1'b0;
        check_eq("accept", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        #2;
        resetn = 1'b0;
        model_reset();
        idle(2);
        resetn = 1'b1;
    endtask

    task automatic check_state(input string tag);
        idle(SC + 2);
        check_eq({tag, "_active"}, 64'(bus.Active), 64'(m_synced));
        check_eq({tag, "_error"}, 64'(bus.Error), 64'(m_error));
        check_eq({tag, "_count"}, 64'(bus.FramesWritten), 64'(m_count));
        check_eq({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        int          r;
        bus.WriteData    = '0;
        bus.WriteStrobe  = 1'b0;
        busb.WriteData   = '0;
        busb.WriteStrobe = 1'b0;
        model_reset();

        // Reset values.
        do_reset();
        check_eq("rst_ready", 64'(bus.Ready), 64'd1);
        check_eq("rst_active", 64'(bus.Active), 64'd0);
        check_eq("rst_error", 64'(bus.Error), 64'd0);
        check_eq("rst_count", 64'(bus.FramesWritten), 64'd0);
        check_eq("rst_fdata", 64'(bus.FrameData), 64'd0);
        check_eq("rst_strobe", 64'(strobe_code(bus.FrameStrobe)), 64'd999);

        // Basic write: column 3 frame 5.
        send_word(SYNC);
        send_word(32'h0100_0305);
        send_word(32'hDEAD_BEEF);
        check_eq("t1_bit101_c1", 64'(strobe_code(bus.FrameStrobe)), 64'd101);
        check_eq("t1_ready_c1", 64'(bus.Ready), 64'd0);
        idle(1);
        check_eq("t1_bit101_c2", 64'(strobe_code(bus.FrameStrobe)), 64'd101);
        check_eq("t1_ready_c2", 64'(bus.Ready), 64'd0);
        idle(1);
        check_eq("t1_strobe_off", 64'(strobe_code(bus.FrameStrobe)), 64'd999);
        check_eq("t1_ready_back", 64'(bus.Ready), 64'd1);
        check_eq("t1_fdata", 64'(bus.FrameData), 64'hDEAD_BEEF);
        check_eq("t1_count", 64'(bus.FramesWritten), 64'd1);
        check_eq("t1_active", 64'(bus.Active), 64'd1);

        // Unsynced traffic is discarded.
        do_reset();
        send_word(32'h0100_0000);
        send_word(32'h1234_5678);
        check_state("t2");
        check_eq("t2_fdata", 64'(bus.FrameData), 64'd0);

        // Out-of-range column flags Error, then a resync still writes.
        do_reset();
        send_word(SYNC);
        send_word(32'h0100_0800);
        idle(1);
        check_eq("t3_error", 64'(bus.Error), 64'd1);
        check_eq("t3_active", 64'(bus.Active), 64'd0);
        send_word(32'h1234_5678);
        send_word(SYNC);
        send_word(32'h0100_0102);
        send_word(32'hCAFE_0001);
        check_state("t3");

        // Back-to-back pairs at both index extremes, then desync.
        do_reset();
        send_word(SYNC);
        send_word(32'h0100_0000);
        send_word(32'h1111_0000);
        send_word(32'h0100_071F);
        send_word(32'h2222_00FF);
        send_word(32'h0F00_0000);
        check_state("t4");
        check_eq("t4_count2", 64'(bus.FramesWritten), 64'd2);

        // Asynchronous reset in the first strobe cycle.
        do_reset();
        send_word(SYNC);
        send_word(32'h0100_0203);
        send_word(32'h5A5A_5A5A);
        #1;
        check_eq("t5_pre", 64'(strobe_code(bus.FrameStrobe)), 64'd67);
        resetn = 1'b0;
        model_reset();
        #1;
        check_eq("t5_strobe", 64'(strobe_code(bus.FrameStrobe)), 64'd999);
        check_eq("t5_fdata", 64'(bus.FrameData), 64'd0);
        #3;
        resetn = 1'b1;
        idle(1);
        check_eq("t5_active", 64'(bus.Active), 64'd0);
        check_eq("t5_count", 64'(bus.FramesWritten), 64'd0);

        // Random word streams.
        do_reset();
        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: send_word(SYNC);
                1, 2, 3, 4, 5: begin
                    w = {8'h01, 8'($urandom), 8'($urandom_range(0, NC - 1)),
                         3'($urandom), 5'($urandom_range(0, MF - 1))};
                    send_word(w);
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                    send_word($urandom);
                end
                6: send_word({8'h0F, 24'($urandom)});
                7: send_word({8'h01, 8'($urandom), 8'($urandom_range(NC, 255)), 8'($urandom)});
                8: send_word({8'($urandom_range(8'h10, 8'hF9)), 24'($urandom)});
                default: send_word($urandom);
            endcase
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        check_state("rand");

        // StrobeCycles=1 build: next header held through the strobe cycle.
        busb.WriteStrobe = 1'b1;
        busb.WriteData   = SYNC;
        idle(1);
        busb.WriteData = 32'h0100_0203;
        idle(1);
        busb.WriteData = 32'hA5A5_A5A5;
        idle(1);
        busb.WriteData = 32'h0100_0104;
        check_eq("sc1_strobe_on", 64'(strobe_code(busb.FrameStrobe)), 64'd67);
        check_eq("sc1_ready_low", 64'(busb.Ready), 64'd0);
        check_eq("sc1_fdata", 64'(busb.FrameData), 64'hA5A5_A5A5);
        idle(1);
        check_eq("sc1_strobe_off", 64'(strobe_code(busb.FrameStrobe)), 64'd999);
        check_eq("sc1_ready_back", 64'(busb.Ready), 64'd1);
        idle(1);
        busb.WriteData = 32'h1111_1111;
        idle(1);
        busb.WriteStrobe = 1'b0;
        check_eq("sc1_strobe2", 64'(strobe_code(busb.FrameStrobe)), 64'd36);
        check_eq("sc1_fdata2", 64'(busb.FrameData), 64'h1111_1111);
        idle(1);
        check_eq("sc1_strobe2_off", 64'(strobe_code(busb.FrameStrobe)), 64'd999);
        check_eq("sc1_count", 64'(busb.FramesWritten), 64'd2);
        check_eq("sc1_active", 64'(busb.Active), 64'd1);
        check_eq("sc1_error", 64'(busb.Error), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
